// File: rtl/fs_shift_pkg.sv
// Shared definitions for the multi-lane shift register.
//   MODE_*  : per-lane operation codes
//   dir_e   : last shift direction, selects which end drives SO
//   fill_w  : width of the per-lane fill counter
package fs_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        DirLeft  = 1'b0,
        DirRight = 1'b1
    } dir_e;

    function automatic int unsigned fill_w(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fs_shift_multi_if.sv
// Bus bundle for fs_shift_multi.
//   ce   : per-lane clock enable
//   mode : per-lane op, 2 bits per lane
//   sd   : per-lane serial in
//   pd   : per-lane parallel load data, lane k at [k*DEPTH +: DEPTH]
//   q    : per-lane register contents
//   so   : per-lane serial out
//   full : per-lane fill indicator
// master drives the controls and observes the results; slave is the shift register.
interface fs_shift_multi_if #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CHANNELS = 1
);
    logic [CHANNELS-1:0]       ce;
    logic [2*CHANNELS-1:0]     mode;
    logic [CHANNELS-1:0]       sd;
    logic [DEPTH*CHANNELS-1:0] pd;
    logic [DEPTH*CHANNELS-1:0] q;
    logic [CHANNELS-1:0]       so;
    logic [CHANNELS-1:0]       full;

    modport master (
        output ce, mode, sd, pd,
        input  q, so, full
    );

    modport slave (
        input  ce, mode, sd, pd,
        output q, so, full
    );
endinterface

// File: rtl/fs_shift_lane.sv
// One lane of the multi-channel shift register: holds Q, the fill counter and the
// last shift direction.
//   clk_i  : clock; active edge is falling when NEG_EDGE=1, rising otherwise
//   rst_ni : asynchronous active-low reset
//   ce_i   : lane enable, 0 holds all state regardless of mode_i
//   mode_i : 00 hold, 01 shift-left, 10 shift-right, 11 load
//   sd_i   : serial in (stored inverted when INVERT_IN=1)
//   pd_i   : parallel load data
//   q_o    : register contents
//   so_o   : Q[DEPTH-1] after a left shift, Q[0] after a right shift
//   full_o : DEPTH serial bits taken since reset/load, or just loaded
module fs_shift_lane
    import fs_shift_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     NEG_EDGE  = 1,
    parameter int unsigned     INVERT_IN = 1,
    parameter logic [DEPTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic [1:0]       mode_i,
    input  logic             sd_i,
    input  logic [DEPTH-1:0] pd_i,
    output logic [DEPTH-1:0] q_o,
    output logic             so_o,
    output logic             full_o
);

    localparam int unsigned      FillW   = fill_w(DEPTH);
    localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

    // Edge select by inverting the clock; CE stays in the data path.
    logic clk_int;
    assign clk_int = (NEG_EDGE != 0) ? ~clk_i : clk_i;

    logic s;
    assign s = (INVERT_IN != 0) ? ~sd_i : sd_i;

    logic [DEPTH-1:0] q_q, q_d;
    logic [FillW-1:0] fill_q, fill_d;
    dir_e             dir_q, dir_d;

    always_comb begin
        q_d    = q_q;
        fill_d = fill_q;
        dir_d  = dir_q;
        if (ce_i) begin
            unique case (mode_i)
                MODE_HOLD: ;
                MODE_SHL: begin
                    q_d   = {q_q[DEPTH-2:0], s};
                    dir_d = DirLeft;
                    if (fill_q != FillMax) fill_d = fill_q + FillW'(1);
                end
                MODE_SHR: begin
                    q_d   = {s, q_q[DEPTH-1:1]};
                    dir_d = DirRight;
                    if (fill_q != FillMax) fill_d = fill_q + FillW'(1);
                end
                MODE_LOAD: begin
                    q_d    = pd_i;
                    fill_d = FillMax;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= RESET_VAL;
            fill_q <= '0;
            dir_q  <= DirLeft;
        end else begin
            q_q    <= q_d;
            fill_q <= fill_d;
            dir_q  <= dir_d;
        end
    end

    assign q_o    = q_q;
    assign so_o   = (dir_q == DirLeft) ? q_q[DEPTH-1] : q_q[0];
    assign full_o = (fill_q == FillMax);

endmodule

// File: rtl/fs_shift_multi.sv
// Multi-channel shift register: CHANNELS independent lanes of DEPTH bits, each with
// hold / shift-left / shift-right / load and fill tracking.
//   ck_i   : clock, active edge per NEG_EDGE
//   rst_ni : asynchronous active-low reset, dominates all other inputs
//   bus    : slave side of fs_shift_multi_if (ce, mode, sd, pd in; q, so, full out)
module fs_shift_multi
    import fs_shift_pkg::*;
#(
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      CHANNELS  = 1,
    parameter int unsigned      NEG_EDGE  = 1,
    parameter int unsigned      INVERT_IN = 1,
    parameter logic [DEPTH-1:0] RESET_VAL = '0
) (
    input  logic              ck_i,
    input  logic              rst_ni,
    fs_shift_multi_if.slave   bus
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        fs_shift_lane #(
            .DEPTH     (DEPTH),
            .NEG_EDGE  (NEG_EDGE),
            .INVERT_IN (INVERT_IN),
            .RESET_VAL (RESET_VAL)
        ) u_lane (
            .clk_i  (ck_i),
            .rst_ni (rst_ni),
            .ce_i   (bus.ce[k]),
            .mode_i (bus.mode[2*k +: 2]),
            .sd_i   (bus.sd[k]),
            .pd_i   (bus.pd[k*DEPTH +: DEPTH]),
            .q_o    (bus.q[k*DEPTH +: DEPTH]),
            .so_o   (bus.so[k]),
            .full_o (bus.full[k])
        );
    end

endmodule
